// File: rtl/fb_pkg.sv
// Shared framebuffer definitions: display geometry, pixel/address types
// and the state encoding used by the framebuffer write arbiter.
package fb_pkg;

  localparam int DISPLAY_WIDTH  = 320;
  localparam int DISPLAY_HEIGHT = 240;
  localparam int FB_DATA_WIDTH  = 16;
  localparam int FB_DATA_N      = DISPLAY_WIDTH * DISPLAY_HEIGHT;
  localparam int FB_ADDR_BITS   = $clog2(FB_DATA_N);

  typedef logic [FB_ADDR_BITS-1:0]  fb_addr_t;
  typedef logic [FB_DATA_WIDTH-1:0] fb_pixel_t;

  typedef enum logic {
    ARB   = 1'b0,
    CLEAR = 1'b1
  } fb_arb_state_t;

  // An index into N things still needs one bit when N is 1.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fb_write_arbiter_rr.sv
// Combinational round-robin picker: first asserted request at or after
// ptr_i (wrapping), reported both one-hot and as an index.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               valid_o
);

  always_comb begin
    int cand;
    grant_o = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = (int'(ptr_i) + k) % NUM_REQ;
      if (!valid_o && req_i[cand]) begin
        valid_o       = 1'b1;
        idx_o         = IDX_W'(cand);
        grant_o[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fb_write_arbiter.sv
// Round-robin arbiter for the framebuffer RAM write port, with a built-in
// clear sequencer that fills every pixel with one colour.
module fb_write_arbiter
  import fb_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = FB_DATA_WIDTH,
  parameter int DATA_N     = FB_DATA_N,
  parameter int ADDR_BITS  = $clog2(DATA_N),
  localparam int GID_W     = idx_width(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*ADDR_BITS-1:0]  req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic                          clear_start,
  input  logic [DATA_WIDTH-1:0]         clear_color,
  output logic                          clear_busy,
  output logic                          clear_done,
  output logic                          addr_err,
  output logic [GID_W-1:0]              grant_id,
  output logic                          fb_wr_en,
  output logic [ADDR_BITS-1:0]          fb_wr_addr,
  output logic [DATA_WIDTH-1:0]         fb_wr_in
);

  localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(DATA_N - 1);
  localparam logic [GID_W-1:0]     LAST_ID   = GID_W'(NUM_REQ - 1);

  fb_arb_state_t            state_q, state_d;
  logic [GID_W-1:0]         rr_ptr_q, rr_ptr_d;
  logic [ADDR_BITS-1:0]     cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]    color_q, color_d;
  logic                     wr_en_q, wr_en_d;
  logic [ADDR_BITS-1:0]     wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0]    wr_data_q, wr_data_d;
  logic [GID_W-1:0]         gid_q, gid_d;
  logic                     done_q, done_d;
  logic                     err_q, err_d;

  logic [NUM_REQ-1:0]       arb_grant;
  logic [GID_W-1:0]         arb_idx;
  logic                     arb_any;
  logic [ADDR_BITS-1:0]     sel_addr;
  logic [DATA_WIDTH-1:0]    sel_data;
  logic                     sel_addr_ok;
  logic                     accept;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (GID_W)
  ) u_rr (
    .req_i   (req_valid),
    .ptr_i   (rr_ptr_q),
    .grant_o (arb_grant),
    .idx_o   (arb_idx),
    .valid_o (arb_any)
  );

  assign sel_addr    = req_addr[int'(arb_idx)*ADDR_BITS +: ADDR_BITS];
  assign sel_data    = req_data[int'(arb_idx)*DATA_WIDTH +: DATA_WIDTH];
  assign sel_addr_ok = (int'(sel_addr) < DATA_N);

  // A clear request in ARB pre-empts every requester for that cycle.
  assign accept = (state_q == ARB) && !clear_start && arb_any;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ARB;
      rr_ptr_q  <= '0;
      cnt_q     <= '0;
      color_q   <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      gid_q     <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      cnt_q     <= cnt_d;
      color_q   <= color_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      gid_q     <= gid_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  // Address/data registers hold when nothing is written so the RAM port
  // only sees new values alongside a write enable.
  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    cnt_d     = cnt_q;
    color_d   = color_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    gid_d     = gid_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      ARB: begin
        if (clear_start) begin
          state_d = CLEAR;
          color_d = clear_color;
          cnt_d   = '0;
        end else if (accept) begin
          rr_ptr_d = (arb_idx == LAST_ID) ? '0 : arb_idx + GID_W'(1);
          gid_d    = arb_idx;
          if (sel_addr_ok) begin
            wr_en_d   = 1'b1;
            wr_addr_d = sel_addr;
            wr_data_d = sel_data;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      CLEAR: begin
        wr_en_d   = 1'b1;
        wr_addr_d = cnt_q;
        wr_data_d = color_q;
        if (cnt_q == LAST_ADDR) begin
          state_d = ARB;
          done_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ADDR_BITS'(1);
        end
      end
      default: state_d = ARB;
    endcase
  end

  // req_ready is gated by the reset input so it reads zero while held.
  always_comb begin
    req_ready  = (accept && rst) ? arb_grant : '0;
    clear_busy = (state_q == CLEAR);
    clear_done = done_q;
    addr_err   = err_q;
    grant_id   = gid_q;
    fb_wr_en   = wr_en_q;
    fb_wr_addr = wr_addr_q;
    fb_wr_in   = wr_data_q;
  end

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Scoreboard bench for fb_write_arbiter: a small arbitration/clear model
// predicts each cycle's write port state one cycle ahead.
module tb_fb_write_arbiter;

  localparam int NREQ = 2;
  localparam int DW   = 16;
  localparam int DN   = 76800;
  localparam int AB   = 17;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*AB-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic              clear_start;
  logic [DW-1:0]     clear_color;
  logic              clear_busy;
  logic              clear_done;
  logic              addr_err;
  logic              grant_id;
  logic              fb_wr_en;
  logic [AB-1:0]     fb_wr_addr;
  logic [DW-1:0]     fb_wr_in;

  fb_write_arbiter #(
    .NUM_REQ    (NREQ),
    .DATA_WIDTH (DW),
    .DATA_N     (DN)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .req_data    (req_data),
    .clear_start (clear_start),
    .clear_color (clear_color),
    .clear_busy  (clear_busy),
    .clear_done  (clear_done),
    .addr_err    (addr_err),
    .grant_id    (grant_id),
    .fb_wr_en    (fb_wr_en),
    .fb_wr_addr  (fb_wr_addr),
    .fb_wr_in    (fb_wr_in)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          en;
    logic [AB-1:0] addr;
    logic [DW-1:0] data;
    logic          err;
    logic          done;
    logic          gid;
  } expT;

  expT expQ[$];

  int total = 0;
  int bad   = 0;

  int            mPtr;
  logic          mInClear;
  int            mCnt;
  logic [DW-1:0] mColor;
  logic [AB-1:0] mAddr;
  logic [DW-1:0] mData;
  logic          mGid;

  int            doneSeen;
  int            errSeen;
  int            clearWrites;
  logic [AB-1:0] doneAddr;
  int            g0;
  int            g1;
  int            wrCnt;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    mPtr     = 0;
    mInClear = 1'b0;
    mCnt     = 0;
    mColor   = '0;
    mAddr    = '0;
    mData    = '0;
    mGid     = 1'b0;
    expQ.delete();
  endtask

  task automatic checkWrite();
    expT e;
    checkOutput("queue_depth", 64'(expQ.size()), 64'(1));
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      checkOutput("fb_wr_en", 64'(fb_wr_en), 64'(e.en));
      checkOutput("fb_wr_addr", 64'(fb_wr_addr), 64'(e.addr));
      checkOutput("fb_wr_in", 64'(fb_wr_in), 64'(e.data));
      checkOutput("addr_err", 64'(addr_err), 64'(e.err));
      checkOutput("clear_done", 64'(clear_done), 64'(e.done));
      checkOutput("grant_id", 64'(grant_id), 64'(e.gid));
    end
    if (clear_done === 1'b1) begin
      doneSeen++;
      doneAddr = fb_wr_addr;
    end
    if (addr_err === 1'b1) errSeen++;
    if (fb_wr_en === 1'b1 && fb_wr_in == 16'h001F) clearWrites++;
  endtask

  // Drive one cycle of inputs, check the combinational outputs against the
  // model, queue the predicted registered outputs and check them after the edge.
  task automatic applyStimulus(input logic [1:0] v, input logic [AB-1:0] a0, input logic [AB-1:0] a1,
                               input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                               input logic cs, input logic [DW-1:0] color);
    expT        e;
    logic [1:0] expReady;
    logic       wasClear;
    int         w;
    req_valid   = v;
    req_addr    = {a1, a0};
    req_data    = {d1, d0};
    clear_start = cs;
    clear_color = color;
    #1;
    expReady = '0;
    wasClear = mInClear;
    e.en     = 1'b0;
    e.err    = 1'b0;
    e.done   = 1'b0;
    if (mInClear) begin
      e.en   = 1'b1;
      mAddr  = AB'(mCnt);
      mData  = mColor;
      e.done = (mCnt == DN - 1);
      if (e.done) begin
        mInClear = 1'b0;
        mCnt     = 0;
      end else begin
        mCnt++;
      end
    end else if (cs) begin
      mInClear = 1'b1;
      mColor   = color;
      mCnt     = 0;
    end else begin
      w = -1;
      for (int k = 0; k < NREQ; k++)
        if (w < 0 && v[(mPtr + k) % NREQ]) w = (mPtr + k) % NREQ;
      if (w >= 0) begin
        expReady[w] = 1'b1;
        mPtr        = (w + 1) % NREQ;
        mGid        = w[0];
        if (int'((w == 0) ? a0 : a1) < DN) begin
          e.en  = 1'b1;
          mAddr = (w == 0) ? a0 : a1;
          mData = (w == 0) ? d0 : d1;
        end else begin
          e.err = 1'b1;
        end
      end
    end
    e.addr = mAddr;
    e.data = mData;
    e.gid  = mGid;
    checkOutput("req_ready", 64'(req_ready), 64'(expReady));
    checkOutput("clear_busy", 64'(clear_busy), 64'(wasClear));
    expQ.push_back(e);
    @(posedge clk);
    #1;
    checkWrite();
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_ready"}, 64'(req_ready), 64'(0));
    checkOutput({tag, "_wr_en"}, 64'(fb_wr_en), 64'(0));
    checkOutput({tag, "_wr_addr"}, 64'(fb_wr_addr), 64'(0));
    checkOutput({tag, "_wr_in"}, 64'(fb_wr_in), 64'(0));
    checkOutput({tag, "_busy"}, 64'(clear_busy), 64'(0));
    checkOutput({tag, "_done"}, 64'(clear_done), 64'(0));
    checkOutput({tag, "_err"}, 64'(addr_err), 64'(0));
    checkOutput({tag, "_gid"}, 64'(grant_id), 64'(0));
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: run exceeded its time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst         = 1'b0;
    req_valid   = '0;
    req_addr    = '0;
    req_data    = '0;
    clear_start = 1'b0;
    clear_color = '0;
    modelReset();
    doneSeen    = 0;
    errSeen     = 0;
    clearWrites = 0;
    doneAddr    = '0;

    $display("[TB] reset with random inputs");
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      req_valid   = 2'($urandom);
      req_addr    = {2'($urandom), 32'($urandom)};
      req_data    = $urandom;
      clear_start = 1'($urandom);
      clear_color = 16'($urandom);
      #1;
      checkAllZero("rst");
    end
    @(posedge clk);
    #1;
    rst         = 1'b1;
    req_valid   = '0;
    clear_start = 1'b0;

    $display("[TB] first request after reset");
    applyStimulus(2'b01, 17'd5, 17'd0, 16'hF800, 16'h0000, 1'b0, 16'h0000);
    applyStimulus(2'b00, 17'd0, 17'd0, 16'h0000, 16'h0000, 1'b0, 16'h0000);

    $display("[TB] round robin with both requesters valid");
    g0    = 0;
    g1    = 0;
    wrCnt = 0;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(2'b11, AB'(100 + i), AB'(200 + i), DW'(16'h1000 + i), DW'(16'h2000 + i),
                    1'b0, 16'h0000);
      if (fb_wr_en === 1'b1) begin
        wrCnt++;
        if (grant_id === 1'b1) g1++;
        else g0++;
      end
    end
    checkOutput("rr_writes", 64'(wrCnt), 64'(8));
    checkOutput("rr_grants0", 64'(g0), 64'(4));
    checkOutput("rr_grants1", 64'(g1), 64'(4));
    applyStimulus(2'b00, 17'd0, 17'd0, 16'h0000, 16'h0000, 1'b0, 16'h0000);

    $display("[TB] out of range address");
    errSeen = 0;
    applyStimulus(2'b01, 17'd76800, 17'd0, 16'hBEEF, 16'h0000, 1'b0, 16'h0000);
    applyStimulus(2'b11, 17'd10, 17'd11, 16'h0A0A, 16'h0B0B, 1'b0, 16'h0000);
    applyStimulus(2'b00, 17'd0, 17'd0, 16'h0000, 16'h0000, 1'b0, 16'h0000);
    checkOutput("addr_err_pulses", 64'(errSeen), 64'(1));

    $display("[TB] full clear colliding with requester 1");
    doneSeen    = 0;
    clearWrites = 0;
    applyStimulus(2'b10, 17'd0, 17'd300, 16'h0000, 16'h1234, 1'b1, 16'h001F);
    for (int i = 0; i < DN + 8 && mInClear; i++)
      applyStimulus(2'b10, 17'd0, 17'd300, 16'h0000, 16'h1234, (i == 500), 16'hFFFF);
    applyStimulus(2'b10, 17'd0, 17'd300, 16'h0000, 16'h1234, 1'b0, 16'h0000);
    applyStimulus(2'b00, 17'd0, 17'd0, 16'h0000, 16'h0000, 1'b0, 16'h0000);
    checkOutput("clear_done_count", 64'(doneSeen), 64'(1));
    checkOutput("clear_done_addr", 64'(doneAddr), 64'(DN - 1));
    checkOutput("clear_writes", 64'(clearWrites), 64'(DN));

    $display("[TB] reset in the middle of a clear");
    applyStimulus(2'b00, 17'd0, 17'd0, 16'h0000, 16'h0000, 1'b1, 16'h07E0);
    for (int i = 0; i < 2000 && mInClear && mCnt < 1000; i++)
      applyStimulus(2'b00, 17'd0, 17'd0, 16'h0000, 16'h0000, 1'b0, 16'h0000);
    #2;
    rst = 1'b0;
    #1;
    checkAllZero("abort");
    modelReset();
    doneSeen = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int i = 0; i < 3; i++)
      applyStimulus(2'b00, 17'd0, 17'd0, 16'h0000, 16'h0000, 1'b0, 16'h0000);
    applyStimulus(2'b10, 17'd0, 17'd77, 16'h0000, 16'hABCD, 1'b0, 16'h0000);
    applyStimulus(2'b00, 17'd0, 17'd0, 16'h0000, 16'h0000, 1'b0, 16'h0000);
    checkOutput("abort_no_done", 64'(doneSeen), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
